// File: rtl/vadd_axi_mem_pkg.sv
// Shared types and helpers for the vadd AXI memory responder.
package vadd_axi_mem_pkg;

  localparam int unsigned AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Byte-offset bits within one data word.
  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return $clog2(data_w / 32'd8);
  endfunction

endpackage

// File: rtl/vadd_axi_mem_responder_if.sv
// AXI4 memory-mapped subset (AW/W/B/AR/R, INCR only) between a master and the responder.
interface vadd_axi_mem_responder_if
  import vadd_axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512
) ();

  logic                   awvalid;
  logic                   awready;
  logic [ADDR_W-1:0]      awaddr;
  logic [AXI_LEN_W-1:0]   awlen;

  logic                   wvalid;
  logic                   wready;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W/8-1:0]    wstrb;
  logic                   wlast;

  logic                   bvalid;
  logic                   bready;

  logic                   arvalid;
  logic                   arready;
  logic [ADDR_W-1:0]      araddr;
  logic [AXI_LEN_W-1:0]   arlen;

  logic                   rvalid;
  logic                   rready;
  logic [DATA_W-1:0]      rdata;
  logic                   rlast;

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arlen,
    output rready,
    input  awready, wready, bvalid, arready, rvalid, rdata, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arlen,
    input  rready,
    output awready, wready, bvalid, arready, rvalid, rdata, rlast
  );

endinterface

// File: rtl/vadd_axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read-first read port.
module vadd_axi_mem_ram #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 32'd1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents survive reset; only the output register clears.
  always_ff @(posedge ap_clk) begin
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (wbe[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read-first: a same-edge write lands after this sample.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vadd_axi_mem_responder.sv
// AXI4 INCR-burst memory responder: independent write and read FSMs over a dual-port RAM.
module vadd_axi_mem_responder
  import vadd_axi_mem_pkg::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_MEM_DEPTH_LOG2   = 10
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  vadd_axi_mem_responder_if.slave    s_axi,
  output logic                       proto_err
);

  localparam int unsigned ADDR_LSB = addr_lsb(C_S_AXI_DATA_WIDTH);
  localparam int unsigned IDX_W    = C_MEM_DEPTH_LOG2;
  localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;

  // Write side state
  wr_state_t              w_state;
  logic                   awready_q;
  logic                   wready_q;
  logic                   bvalid_q;
  logic [IDX_W-1:0]       w_idx;
  logic [AXI_LEN_W-1:0]   w_len;
  logic [AXI_LEN_W-1:0]   w_cnt;

  // Read side state
  rd_state_t              r_state;
  logic                   arready_q;
  logic                   rvalid_q;
  logic                   rlast_q;
  logic [IDX_W-1:0]       rd_idx;
  logic [AXI_LEN_W-1:0]   rd_len;
  logic [AXI_LEN_W-1:0]   rd_cnt;

  logic [IDX_W-1:0]       aw_idx;
  logic [IDX_W-1:0]       ar_idx;
  logic                   w_fire;
  logic                   w_last_beat;
  logic                   ar_fire;
  logic                   r_fire;
  logic [STRB_W-1:0]      ram_wbe;
  logic                   ram_re;
  logic [IDX_W-1:0]       ram_raddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata;

  // Byte offset and bits above the memory depth are don't-care.
  logic [C_S_AXI_ADDR_WIDTH-1:0] unused_addr_bits;
  assign unused_addr_bits = s_axi.awaddr ^ s_axi.araddr;

  assign aw_idx      = s_axi.awaddr[ADDR_LSB +: IDX_W];
  assign ar_idx      = s_axi.araddr[ADDR_LSB +: IDX_W];

  assign w_fire      = (w_state == W_DATA) && wready_q && s_axi.wvalid;
  assign w_last_beat = (w_cnt == w_len);
  assign ram_wbe     = w_fire ? s_axi.wstrb : '0;

  assign ar_fire     = (r_state == R_IDLE) && arready_q && s_axi.arvalid;
  assign r_fire      = rvalid_q && s_axi.rready;
  // Fetch the next word only when the presented beat is consumed, so rdata holds while stalled.
  assign ram_re      = ar_fire || (r_fire && !rlast_q);
  assign ram_raddr   = (r_state == R_IDLE) ? ar_idx : rd_idx;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rdata   = ram_rdata;

  // Write FSM: AW latch, beat-counted data phase, single OKAY response.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      proto_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (s_axi.awvalid && awready_q) begin
            w_idx     <= aw_idx;
            w_len     <= s_axi.awlen;
            w_cnt     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx + IDX_W'(1);
            w_cnt <= w_cnt + AXI_LEN_W'(1);
            // Burst length comes from awlen; a disagreeing wlast is only flagged.
            if (s_axi.wlast != w_last_beat) begin
              proto_err <= 1'b1;
            end
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          w_state   <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: AR issues the first RAM read; each consumed non-last beat issues the next.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rd_idx    <= '0;
      rd_len    <= '0;
      rd_cnt    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_fire) begin
            rd_idx    <= ar_idx + IDX_W'(1);
            rd_len    <= s_axi.arlen;
            rd_cnt    <= '0;
            rlast_q   <= (s_axi.arlen == AXI_LEN_W'(0));
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              rd_idx  <= rd_idx + IDX_W'(1);
              rd_cnt  <= rd_cnt + AXI_LEN_W'(1);
              rlast_q <= ((rd_cnt + AXI_LEN_W'(1)) == rd_len);
            end
          end
        end
        default: begin
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
          arready_q <= 1'b0;
          r_state   <= R_IDLE;
        end
      endcase
    end
  end

  vadd_axi_mem_ram #(
    .DATA_W     (C_S_AXI_DATA_WIDTH),
    .DEPTH_LOG2 (C_MEM_DEPTH_LOG2)
  ) u_ram (
    .ap_clk (ap_clk),
    .areset (areset),
    .wbe    (ram_wbe),
    .waddr  (w_idx),
    .wdata  (s_axi.wdata),
    .re     (ram_re),
    .raddr  (ram_raddr),
    .rdata  (ram_rdata)
  );

endmodule

// File: tb/tb_vadd_axi_mem_responder.sv
// Self-checking bench: strobe vector table, burst scenarios, and an R-channel scoreboard.
module tb_vadd_axi_mem_responder;

  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 512;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned DL    = 10;
  localparam int unsigned DEPTH = 1024;

  logic ap_clk = 1'b0;
  logic areset;
  logic proto_err;

  always #5 ap_clk = ~ap_clk;

  vadd_axi_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) s_axi ();

  vadd_axi_mem_responder #(
    .C_S_AXI_ADDR_WIDTH (AW),
    .C_S_AXI_DATA_WIDTH (DW),
    .C_MEM_DEPTH_LOG2   (DL)
  ) dut (
    .ap_clk    (ap_clk),
    .areset    (areset),
    .s_axi     (s_axi),
    .proto_err (proto_err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } rexp_t;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  rexp_t         exp_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] wbuf  [256];
  logic [SW-1:0] sbuf  [256];
  vec_t          vt    [5];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [AW-1:0] a, input int unsigned i);
    return (32'(a[6 +: DL]) + i) % DEPTH;
  endfunction

  task automatic push_model(input logic [AW-1:0] a, input int unsigned len);
    for (int unsigned i = 0; i <= len; i++) exp_q.push_back({model[widx(a, i)], i == len});
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input int unsigned len, input int wlast_at);
    bit hs;
    int n;
    int nb;
    s_axi.awaddr = a; s_axi.awlen = 8'(len); s_axi.awvalid = 1'b1;
    n = 0;
    do begin hs = s_axi.awready; @(posedge ap_clk); #1; n++; end while (!hs && n < 100);
    s_axi.awvalid = 1'b0;
    chk("aw_handshake", hs, 1);
    for (int unsigned i = 0; i <= len; i++) begin
      s_axi.wvalid = 1'b1; s_axi.wdata = wbuf[i]; s_axi.wstrb = sbuf[i];
      s_axi.wlast  = (wlast_at < 0) ? (i == len) : (int'(i) == wlast_at);
      n = 0;
      do begin hs = s_axi.wready; @(posedge ap_clk); #1; n++; end while (!hs && n < 100);
      if (hs) begin
        for (int b = 0; b < int'(SW); b++)
          if (sbuf[i][b]) model[widx(a, i)][b*8 +: 8] = wbuf[i][b*8 +: 8];
      end
      chk("w_handshake", hs, 1);
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    chk("wready_after_last", s_axi.wready, 0);
    s_axi.bready = 1'b1;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      hs = s_axi.bvalid; @(posedge ap_clk); #1;
      if (hs) nb++;
    end
    s_axi.bready = 1'b0;
    chk("b_count", nb, 1);
  endtask

  task automatic ar_req(input logic [AW-1:0] a, input int unsigned len);
    bit hs;
    int n;
    s_axi.araddr = a; s_axi.arlen = 8'(len); s_axi.arvalid = 1'b1;
    n = 0;
    do begin hs = s_axi.arready; @(posedge ap_clk); #1; n++; end while (!hs && n < 100);
    s_axi.arvalid = 1'b0;
    chk("ar_handshake", hs, 1);
  endtask

  // Consume n beats, popping the scoreboard per handshake and checking hold on stalls.
  task automatic rx_beats(input int n, input bit bp);
    int got;
    int cyc;
    bit v;
    bit r;
    logic [DW-1:0] d;
    logic l;
    rexp_t e;
    got = 0; cyc = 0;
    while (got < n && cyc < 2000) begin
      s_axi.rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      v = s_axi.rvalid; r = s_axi.rready; d = s_axi.rdata; l = s_axi.rlast;
      @(posedge ap_clk); #1; cyc++;
      if (v && r) begin
        chk("r_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("r_data", d, e.data);
          chk("r_last", l, e.last);
        end
        got++;
      end else if (v) begin
        chk("r_hold_data", s_axi.rdata, d);
        chk("r_hold_last", s_axi.rlast, l);
      end
    end
    s_axi.rready = 1'b0;
    chk("r_beats", got, n);
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input int unsigned len, input bit bp);
    int extra;
    ar_req(a, len);
    rx_beats(int'(len) + 1, bp);
    s_axi.rready = 1'b1;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      if (s_axi.rvalid) extra++;
      @(posedge ap_clk); #1;
    end
    s_axi.rready = 1'b0;
    chk("r_no_extra", extra, 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_axi.awvalid = 0; s_axi.awaddr = '0; s_axi.awlen = '0;
    s_axi.wvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 0;
    s_axi.bready = 0; s_axi.arvalid = 0; s_axi.araddr = '0; s_axi.arlen = '0;
    s_axi.rready = 0;
    areset = 1'b1;

    vt[0] = '{64'h1000, 64'h1000, '1, {16{32'h0123_4567}}, {16{32'h0123_4567}}};
    vt[1] = '{64'h1040, 64'h1040, 64'h0F, {16{32'h1122_3344}}, {{60{8'hFF}}, 32'h1122_3344}};
    vt[2] = '{64'h1080, 64'h1080, '0, '0, '1};
    vt[3] = '{64'h10C0, 64'h10C0, 64'h8000_0000_0000_0000, {64{8'hAB}}, {8'hAB, {63{8'hFF}}}};
    vt[4] = '{64'hDEAD_0000_0000_2023, 64'h2000, '1, {16{32'h5A5A_A5A5}}, {16{32'h5A5A_A5A5}}};

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_awready", s_axi.awready, 0);
    chk("rst_wready", s_axi.wready, 0);
    chk("rst_bvalid", s_axi.bvalid, 0);
    chk("rst_arready", s_axi.arready, 0);
    chk("rst_rvalid", s_axi.rvalid, 0);
    chk("rst_rlast", s_axi.rlast, 0);
    chk("rst_rdata", s_axi.rdata, 0);
    chk("rst_proto_err", proto_err, 0);
    areset = 1'b0;
    @(posedge ap_clk); #1;
    chk("post_rst_awready", s_axi.awready, 1);
    chk("post_rst_arready", s_axi.arready, 1);

    // Four-beat write then read of the same burst
    for (int i = 0; i < 4; i++) begin wbuf[i] = DW'(i + 1); sbuf[i] = '1; end
    wr_burst(64'h40, 3, -1);
    for (int i = 0; i < 4; i++) exp_q.push_back({DW'(i + 1), i == 3});
    rd_burst(64'h40, 3, 1'b0);

    // Strobe vectors written over an all-ones word
    for (int v = 0; v < 5; v++) begin
      wbuf[0] = '1; sbuf[0] = '1;
      wr_burst(vt[v].waddr, 0, -1);
      wbuf[0] = vt[v].data; sbuf[0] = vt[v].strb;
      wr_burst(vt[v].waddr, 0, -1);
      exp_q.push_back({vt[v].exp, 1'b1});
      rd_burst(vt[v].raddr, 0, 1'b0);
    end

    // Index wrap from the last word to word 0
    wbuf[0] = {16{32'hA000_03FF}}; wbuf[1] = {16{32'hB000_0000}};
    sbuf[0] = '1; sbuf[1] = '1;
    wr_burst(64'(1023 * 64), 1, -1);
    exp_q.push_back({{16{32'hA000_03FF}}, 1'b0});
    exp_q.push_back({{16{32'hB000_0000}}, 1'b1});
    rd_burst(64'(1023 * 64), 1, 1'b0);
    exp_q.push_back({{16{32'hB000_0000}}, 1'b1});
    rd_burst(64'h0, 0, 1'b0);

    // 16-beat read under random backpressure
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 16; k++) wbuf[i][k*32 +: 32] = $urandom();
      sbuf[i] = '1;
    end
    wr_burst(64'h4000, 15, -1);
    push_model(64'h4000, 15);
    rd_burst(64'h4000, 15, 1'b1);

    // Early wlast still completes the awlen-counted burst
    chk("proto_err_clean", proto_err, 0);
    for (int i = 0; i < 4; i++) begin wbuf[i] = {16{32'hC0DE_0000 + 32'(i)}}; sbuf[i] = '1; end
    wr_burst(64'h9000, 3, 2);
    chk("proto_err_set", proto_err, 1);
    push_model(64'h9000, 3);
    rd_burst(64'h9000, 3, 1'b0);

    // Reset on read beat 2 of 8
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) wbuf[i][k*32 +: 32] = $urandom();
      sbuf[i] = '1;
    end
    wr_burst(64'h8000, 7, -1);
    push_model(64'h8000, 7);
    ar_req(64'h8000, 7);
    rx_beats(2, 1'b0);
    chk("rvalid_before_reset", s_axi.rvalid, 1);
    areset = 1'b1;
    @(posedge ap_clk); #1;
    chk("mid_rst_rvalid", s_axi.rvalid, 0);
    chk("mid_rst_rlast", s_axi.rlast, 0);
    chk("mid_rst_arready", s_axi.arready, 0);
    chk("mid_rst_proto_err", proto_err, 0);
    areset = 1'b0;
    @(posedge ap_clk); #1;
    chk("after_rst_arready", s_axi.arready, 1);
    chk("after_rst_awready", s_axi.awready, 1);
    chk("after_rst_rvalid", s_axi.rvalid, 0);
    exp_q.delete();
    push_model(64'h8000, 7);
    rd_burst(64'h8000, 7, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back({DW'(i + 1), i == 3});
    rd_burst(64'h40, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
